// File: rtl/zip_stream_narrow.sv
// Wide-to-narrow valid/ready width converter: one IW-bit word per handshake
// is emitted as up to IW/OW consecutive OW-bit beats.
module zip_stream_narrow #(
    parameter int IW            = 32,
    parameter int OW            = 8,
    parameter bit OPT_LSB_FIRST = 1'b1,
    parameter bit OPT_LOWPOWER  = 1'b0,
    localparam int R            = IW / OW,
    localparam int CW           = $clog2(R + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [IW-1:0] i_data,
    input  logic [CW-1:0] i_count,
    input  logic          i_last,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [OW-1:0] o_data,
    output logic          o_last
);

    localparam logic [CW-1:0] R_CNT = CW'(R);
    localparam logic [CW-1:0] ONE   = CW'(1);
    localparam logic [CW-1:0] TWO   = CW'(2);

    logic [IW-1:0] sreg;
    logic [CW-1:0] rem;
    logic          r_last;

    logic          accept, take;
    logic [CW-1:0] cnt;
    logic [OW-1:0] in_beat, sreg_beat;
    logic [IW-1:0] in_rest, sreg_rest;

    assign o_ready = !i_reset && (!o_valid || (i_ready && rem == ONE));
    assign accept  = i_valid && o_ready;
    assign take    = o_valid && i_ready;
    assign cnt     = (i_count > R_CNT) ? R_CNT : i_count;

    // The shift register always presents its next beat at the same end,
    // so advancing is a fixed-position read plus a shift.
    assign in_beat   = OPT_LSB_FIRST ? i_data[OW-1:0]  : i_data[IW-1 -: OW];
    assign in_rest   = OPT_LSB_FIRST ? (i_data >> OW)  : (i_data << OW);
    assign sreg_beat = OPT_LSB_FIRST ? sreg[OW-1:0]    : sreg[IW-1 -: OW];
    assign sreg_rest = OPT_LSB_FIRST ? (sreg >> OW)    : (sreg << OW);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sreg    <= '0;
            rem     <= '0;
            r_last  <= 1'b0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
        end else if (accept) begin
            rem    <= cnt;
            r_last <= i_last;
            if (cnt == '0) begin
                // Zero-beat word: swallowed, nothing emitted.
                o_valid <= 1'b0;
                o_last  <= 1'b0;
                if (OPT_LOWPOWER) begin
                    o_data <= '0;
                    sreg   <= '0;
                end
            end else begin
                o_valid <= 1'b1;
                o_data  <= in_beat;
                sreg    <= in_rest;
                o_last  <= i_last && (cnt == ONE);
            end
        end else if (take && rem > ONE) begin
            o_data <= sreg_beat;
            sreg   <= sreg_rest;
            rem    <= rem - ONE;
            o_last <= r_last && (rem == TWO);
        end else if (take) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            rem     <= '0;
            if (OPT_LOWPOWER) begin
                o_data <= '0;
                sreg   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_zip_stream_narrow.sv
// Bench for zip_stream_narrow: LSB-first, MSB-first and low-power instances
// share one stimulus stream; each is checked against hand-computed beats.
module tb_zip_stream_narrow;

    localparam int IW = 32;
    localparam int OW = 8;
    localparam int CW = 3;

    logic          i_clk = 1'b0;
    logic          i_reset, i_valid, i_last, i_ready;
    logic [IW-1:0] i_data;
    logic [CW-1:0] i_count;

    logic          o_ready0, o_valid0, o_last0;
    logic          o_ready1, o_valid1, o_last1;
    logic          o_ready2, o_valid2, o_last2;
    logic [OW-1:0] o_data0, o_data1, o_data2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    zip_stream_narrow #(.IW(IW), .OW(OW), .OPT_LSB_FIRST(1'b1), .OPT_LOWPOWER(1'b0)) u_lsb (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready0),
        .i_data(i_data), .i_count(i_count), .i_last(i_last), .o_valid(o_valid0),
        .i_ready(i_ready), .o_data(o_data0), .o_last(o_last0));

    zip_stream_narrow #(.IW(IW), .OW(OW), .OPT_LSB_FIRST(1'b0), .OPT_LOWPOWER(1'b0)) u_msb (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready1),
        .i_data(i_data), .i_count(i_count), .i_last(i_last), .o_valid(o_valid1),
        .i_ready(i_ready), .o_data(o_data1), .o_last(o_last1));

    zip_stream_narrow #(.IW(IW), .OW(OW), .OPT_LSB_FIRST(1'b1), .OPT_LOWPOWER(1'b1)) u_lp (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready2),
        .i_data(i_data), .i_count(i_count), .i_last(i_last), .o_valid(o_valid2),
        .i_ready(i_ready), .o_data(o_data2), .o_last(o_last2));

    typedef struct {
        logic          v;
        logic [31:0]   d;
        logic [CW-1:0] c;
        logic          l;
        logic          e_ordy;
        logic          e_v;
        logic [7:0]    e_d;
        logic [7:0]    e_dm;
        logic          e_l;
    } vec_t;

    vec_t tbl[25];
    logic [8:0] q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic [CW-1:0] c,
                                input logic l, input logic eo, input logic ev,
                                input logic [7:0] ed, input logic [7:0] em, input logic el);
        vec_t r;
        r.v = v; r.d = d; r.c = c; r.l = l;
        r.e_ordy = eo; r.e_v = ev; r.e_d = ed; r.e_dm = em; r.e_l = el;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] d, input logic [CW-1:0] c,
                         input logic l, input logic r);
        i_valid = v; i_data = d; i_count = c; i_last = l; i_ready = r;
    endtask

    // One random/drain cycle of the scoreboard run on the LSB and low-power copies.
    task automatic lp_cycle(input logic v, input logic r);
        logic [31:0] d;
        logic [CW-1:0] c;
        logic l;
        logic [8:0] e;
        int n;
        d = $urandom;
        c = CW'($urandom_range(1, 7));
        l = 1'($urandom_range(0, 1));
        @(posedge i_clk); #1;
        drive(v, d, c, l, r);
        @(negedge i_clk);
        if (o_valid0 && i_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL lp_underrun: beat %0h emitted, none expected", o_data0);
            end else begin
                e = q.pop_front();
                chk("lp_data", {24'd0, o_data0}, {24'd0, e[7:0]});
                chk("lp_data_lowpower", {24'd0, o_data2}, {24'd0, e[7:0]});
                chk("lp_last", {31'd0, o_last0}, {31'd0, e[8]});
            end
        end
        if (!o_valid2) chk("lp_idle_zero", {24'd0, o_data2}, 32'd0);
        chk("lp_valid_match", {31'd0, o_valid2}, {31'd0, o_valid0});
        if (i_valid && o_ready0) begin
            n = (int'(c) > 4) ? 4 : int'(c);
            for (int k = 0; k < n; k++) q.push_back({l && (k == n - 1), d[k*8 +: 8]});
        end
    endtask

    initial begin
        logic [7:0] beats[4];
        int pat[7];
        int idx;

        tbl[0]  = mk(1, 32'h44332211, 4, 1, 1, 0, 8'h00, 8'h00, 0);
        tbl[1]  = mk(0, 32'h0,        0, 0, 0, 1, 8'h11, 8'h44, 0);
        tbl[2]  = mk(0, 32'h0,        0, 0, 0, 1, 8'h22, 8'h33, 0);
        tbl[3]  = mk(0, 32'h0,        0, 0, 0, 1, 8'h33, 8'h22, 0);
        tbl[4]  = mk(0, 32'h0,        0, 0, 1, 1, 8'h44, 8'h11, 1);
        tbl[5]  = mk(1, 32'hA3A2A1A0, 4, 0, 1, 0, 8'h44, 8'h11, 0);
        tbl[6]  = mk(0, 32'h0,        0, 0, 0, 1, 8'hA0, 8'hA3, 0);
        tbl[7]  = mk(1, 32'hFFFFFFFF, 4, 0, 0, 1, 8'hA1, 8'hA2, 0);
        tbl[8]  = mk(1, 32'hFFFFFFFF, 4, 0, 0, 1, 8'hA2, 8'hA1, 0);
        tbl[9]  = mk(1, 32'hB3B2B1B0, 4, 1, 1, 1, 8'hA3, 8'hA0, 0);
        tbl[10] = mk(0, 32'h0,        0, 0, 0, 1, 8'hB0, 8'hB3, 0);
        tbl[11] = mk(0, 32'h0,        0, 0, 0, 1, 8'hB1, 8'hB2, 0);
        tbl[12] = mk(0, 32'h0,        0, 0, 0, 1, 8'hB2, 8'hB1, 0);
        tbl[13] = mk(0, 32'h0,        0, 0, 1, 1, 8'hB3, 8'hB0, 1);
        tbl[14] = mk(1, 32'hDEADBEEF, 2, 1, 1, 0, 8'hB3, 8'hB0, 0);
        tbl[15] = mk(0, 32'h0,        0, 0, 0, 1, 8'hEF, 8'hDE, 0);
        tbl[16] = mk(0, 32'h0,        0, 0, 1, 1, 8'hBE, 8'hAD, 1);
        tbl[17] = mk(1, 32'h04030201, 7, 1, 1, 0, 8'hBE, 8'hAD, 0);
        tbl[18] = mk(0, 32'h0,        0, 0, 0, 1, 8'h01, 8'h04, 0);
        tbl[19] = mk(0, 32'h0,        0, 0, 0, 1, 8'h02, 8'h03, 0);
        tbl[20] = mk(0, 32'h0,        0, 0, 0, 1, 8'h03, 8'h02, 0);
        tbl[21] = mk(0, 32'h0,        0, 0, 1, 1, 8'h04, 8'h01, 1);
        tbl[22] = mk(1, 32'h55AA33CC, 1, 1, 1, 0, 8'h04, 8'h01, 0);
        tbl[23] = mk(0, 32'h0,        0, 0, 1, 1, 8'hCC, 8'h55, 1);
        tbl[24] = mk(0, 32'h0,        0, 0, 1, 0, 8'hCC, 8'h55, 0);

        // Reset state
        i_reset = 1'b1;
        drive(0, 32'h0, 0, 0, 1);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_o_ready", {31'd0, o_ready0}, 32'd0);
        chk("rst_o_valid", {31'd0, o_valid0}, 32'd0);
        chk("rst_o_data", {24'd0, o_data0}, 32'd0);
        chk("rst_o_data_lp", {24'd0, o_data2}, 32'd0);
        chk("rst_o_last", {31'd0, o_last0}, 32'd0);

        // Single, back-to-back, MSB-first partial, clamped and one-beat words
        for (int i = 0; i < 25; i++) begin
            @(posedge i_clk); #1;
            i_reset = 1'b0;
            drive(tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].l, 1'b1);
            @(negedge i_clk);
            chk($sformatf("tbl%0d_o_ready", i), {31'd0, o_ready0}, {31'd0, tbl[i].e_ordy});
            chk($sformatf("tbl%0d_o_valid", i), {31'd0, o_valid0}, {31'd0, tbl[i].e_v});
            chk($sformatf("tbl%0d_o_valid_msb", i), {31'd0, o_valid1}, {31'd0, tbl[i].e_v});
            chk($sformatf("tbl%0d_o_data", i), {24'd0, o_data0}, {24'd0, tbl[i].e_d});
            chk($sformatf("tbl%0d_o_data_msb", i), {24'd0, o_data1}, {24'd0, tbl[i].e_dm});
            chk($sformatf("tbl%0d_o_data_lp", i), {24'd0, o_data2},
                tbl[i].e_v ? {24'd0, tbl[i].e_d} : 32'd0);
            chk($sformatf("tbl%0d_o_last", i), {31'd0, o_last0}, {31'd0, tbl[i].e_l});
            chk($sformatf("tbl%0d_o_last_msb", i), {31'd0, o_last1}, {31'd0, tbl[i].e_l});
        end

        // Backpressure: i_ready pattern 1,0,0,1,1,0,1 across one 4-beat word
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 1; pat[5] = 0; pat[6] = 1;
        @(posedge i_clk); #1;
        drive(1, 32'h44332211, 4, 1, 1);
        @(negedge i_clk);
        chk("bp_accept_ready", {31'd0, o_ready0}, 32'd1);
        idx = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge i_clk); #1;
            drive(1, 32'hFFFFFFFF, 4, 0, 1'(pat[k]));
            @(negedge i_clk);
            chk($sformatf("bp%0d_o_valid", k), {31'd0, o_valid0}, 32'd1);
            chk($sformatf("bp%0d_o_data", k), {24'd0, o_data0}, {24'd0, beats[idx]});
            chk($sformatf("bp%0d_o_data_msb", k), {24'd0, o_data1}, {24'd0, beats[3-idx]});
            chk($sformatf("bp%0d_o_ready", k), {31'd0, o_ready0},
                {31'd0, (pat[k] == 1) && (idx == 3)});
            chk($sformatf("bp%0d_o_last", k), {31'd0, o_last0}, {31'd0, idx == 3});
            if (pat[k] == 1) idx++;
        end
        // The final handshake also accepted the 0xFFFFFFFF word; drain it.
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk); #1;
            drive(0, 32'h0, 0, 0, 1);
            @(negedge i_clk);
            chk($sformatf("bp_tail%0d_o_data", k), {24'd0, o_data0}, 32'hFF);
        end
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("bp_idle_o_valid", {31'd0, o_valid0}, 32'd0);

        // Reset mid-word, with a word offered in the reset cycle
        @(posedge i_clk); #1;
        drive(1, 32'h44332211, 4, 1, 1);
        @(posedge i_clk); #1;
        drive(0, 32'h0, 0, 0, 1);
        @(negedge i_clk);
        chk("rmw_beat0", {24'd0, o_data0}, 32'h11);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("rmw_beat1", {24'd0, o_data0}, 32'h22);
        @(posedge i_clk); #1;
        i_reset = 1'b1;
        drive(1, 32'h01020304, 4, 0, 1);
        @(negedge i_clk);
        chk("rmw_ready_in_reset", {31'd0, o_ready0}, 32'd0);
        chk("rmw_beat2", {24'd0, o_data0}, 32'h33);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        chk("rmw_o_valid", {31'd0, o_valid0}, 32'd0);
        chk("rmw_o_data", {24'd0, o_data0}, 32'd0);
        chk("rmw_o_data_msb", {24'd0, o_data1}, 32'd0);
        chk("rmw_o_last", {31'd0, o_last0}, 32'd0);
        chk("rmw_o_ready", {31'd0, o_ready0}, 32'd1);
        beats[0] = 8'h04; beats[1] = 8'h03; beats[2] = 8'h02; beats[3] = 8'h01;
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk); #1;
            drive(0, 32'h0, 0, 0, 1);
            @(negedge i_clk);
            chk($sformatf("rmw_next%0d_o_valid", k), {31'd0, o_valid0}, 32'd1);
            chk($sformatf("rmw_next%0d_o_data", k), {24'd0, o_data0}, {24'd0, beats[k]});
            chk($sformatf("rmw_next%0d_o_data_msb", k), {24'd0, o_data1}, {24'd0, beats[3-k]});
            chk($sformatf("rmw_next%0d_o_last", k), {31'd0, o_last0}, 32'd0);
        end
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("rmw_done_o_valid", {31'd0, o_valid0}, 32'd0);

        // Random valid/stall run against a byte scoreboard
        q.delete();
        for (int k = 0; k < 1000; k++)
            lp_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
        for (int k = 0; k < 8; k++) lp_cycle(1'b0, 1'b1);
        chk("lp_drain_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
